// File: rtl/ripple_carry_down_counter.sv
// Ripple-carry down counter built from a chain of T flip-flops (T tied high).
// Stage 0 toggles on the rising edge of clk; every higher stage toggles on the
// rising edge of the stage below it, i.e. when that stage borrows (0 -> 1).
// The result counts down by one per rising clk edge and wraps 0 -> all ones.
// A low reset clears every stage asynchronously; clearing only produces 1 -> 0
// transitions, so it never triggers a higher stage.
module ripple_carry_down_counter #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

    // Clock for each stage: clk for stage 0, the previous stage's output above it.
    logic [WIDTH-1:0] w_stage_clk;

    assign w_stage_clk[0] = clk;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_stage_clk
            assign w_stage_clk[i] = q[i-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_tff
            logic r_q;

            // T flip-flop with T = 1: toggle on each rising edge of its stage clock.
            always_ff @(posedge w_stage_clk[i] or negedge reset) begin
                if (!reset) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= ~r_q;
                end
            end

            assign q[i] = r_q;
        end
    endgenerate

endmodule

// File: tb/tb_ripple_carry_down_counter.sv
// Directed bench for ripple_carry_down_counter (WIDTH = 4).
// Each scenario task drives stimulus and compares q against hand-computed or
// bench-modelled values, sampling 1 ns after clock edges so the ripple settles.
`timescale 1ns/1ps
module tb_ripple_carry_down_counter;

    localparam int W = 4;

    logic [W-1:0] q;
    logic         clk;
    logic         reset;

    int           n_vec;
    int           n_err;

    // Glitch watch for the mid-count reset: flags any bit that rises while armed.
    logic         watch;
    logic [W-1:0] watch_base;
    int           n_glitch;

    ripple_carry_down_counter #(.WIDTH(W)) dut (
        .q     (q),
        .clk   (clk),
        .reset (reset)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record any value that sets a bit that was not set when the watch was armed.
    always @(q) begin
        if (watch && ((q & ~watch_base) != '0)) n_glitch++;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_vec=%0d required finish", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        // reset already low since t=1; hold across several clk edges
        #0;
        n_vec++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_initial: q=%b required %b", q, 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (q !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_pos%0d: q=%b required %b", i, q, 4'b0000);
            end
            @(negedge clk); #1;
            n_vec++;
            if (q !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_neg%0d: q=%b required %b", i, q, 4'b0000);
            end
        end
    endtask

    task automatic test_basic_count();
        logic [W-1:0] exp_tab [5];
        exp_tab = '{4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b1011};
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (q !== exp_tab[i]) begin
                n_err++;
                $display("FAIL basic_edge%0d: q=%b required %b", i + 1, q, exp_tab[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_q;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL wrap_clear: q=%b required %b", q, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q = '0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            exp_q = exp_q - 1'b1;
            n_vec++;
            if (q !== exp_q) begin
                n_err++;
                $display("FAIL wrap_edge%0d: q=%b required %b", i, q, exp_q);
            end
            if (i == 16) begin
                n_vec++;
                if (q !== 4'b0000) begin
                    n_err++;
                    $display("FAIL wrap_16th_zero: q=%b required %b", q, 4'b0000);
                end
            end
            if (i == 17) begin
                n_vec++;
                if (q !== 4'b1111) begin
                    n_err++;
                    $display("FAIL wrap_17th_ones: q=%b required %b", q, 4'b1111);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // six edges from zero: 1111 1110 1101 1100 1011 1010
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (q !== 4'b1010) begin
            n_err++;
            $display("FAIL mid_precount: q=%b required %b", q, 4'b1010);
        end
        // assert reset between edges (3 ns after a rising edge)
        #2;
        watch_base = q;
        n_glitch   = 0;
        watch      = 1'b1;
        reset      = 1'b0;
        #1;
        n_vec++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_async_clear: q=%b required %b", q, 4'b0000);
        end
        @(posedge clk); #1;
        watch = 1'b0;
        n_vec++;
        if (n_glitch !== 0) begin
            n_err++;
            $display("FAIL mid_no_glitch: rising-bit events=%0d required %0d", n_glitch, 0);
        end
        n_vec++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_hold: q=%b required %b", q, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (q !== 4'b1111) begin
            n_err++;
            $display("FAIL mid_after_release: q=%b required %b", q, 4'b1111);
        end
    endtask

    task automatic test_reset_held();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (q !== 4'b0000) begin
                n_err++;
                $display("FAIL held_cycle%0d: q=%b required %b", i, q, 4'b0000);
            end
        end
    endtask

    task automatic test_long_run();
        logic [W-1:0] model;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            model = model - 1'b1;
            n_vec++;
            if (q !== model) begin
                n_err++;
                $display("FAIL long_edge%0d: q=%b required %b", n, q, model);
            end
            // falling edge must leave q unchanged
            @(negedge clk); #1;
            n_vec++;
            if (q !== model) begin
                n_err++;
                $display("FAIL long_fall%0d: q=%b required %b", n, q, model);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        n_glitch   = 0;
        watch      = 1'b0;
        watch_base = '0;
        reset      = 1'b1;
        #1;
        reset      = 1'b0;

        test_reset();
        test_basic_count();
        test_wrap();
        test_mid_reset();
        test_reset_held();
        test_long_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ripple_carry_down_counter.md
RIPPLE_CARRY_DOWN_COUNTER -- requirements
Module: ripple_carry_down_counter

Interface
REQ-001 Parameter WIDTH, default 4, number of counter bits and T flip-flop stages; legal range 2..16.
REQ-002 clk  input  1  counter clock; stage 0 is triggered on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears every stage regardless of clk.
REQ-004 q  output  WIDTH  current count; q[0] is the LSB.
REQ-005 Port order SHALL be q, clk, reset, so positional instantiation (q, clk, reset) connects correctly.

Function
REQ-006 The counter SHALL be built as a ripple chain of WIDTH T flip-flops, each with T tied to 1.
- Each flip-flop toggles its output on every active clock edge.
- Each flip-flop has an asynchronous active-low clear.
REQ-007 Stage 0 SHALL be clocked by the rising edge of clk.
REQ-008 Stage i (i >= 1) SHALL be clocked by the rising edge of q[i-1].
- Stage i therefore toggles when the lower stage borrows (goes 0->1).
- This produces a down count.
REQ-009 Per rising clk edge with reset high, q SHALL settle to (q - 1) mod 2^WIDTH.
- Sequence: 0000, 1111, 1110, 1101, ... 0001, 0000, 1111, ...
REQ-010 Wrap-around: from 0 the next count SHALL be all ones (4'b1111 for WIDTH=4).
- The wrap is ripple-propagated through all stages.
- No extra flag or output is produced on wrap.
REQ-011 Ripple timing is inherent.
- Upper bits MAY change after lower bits within the same clk cycle.
- All bits SHALL be stable before the next rising clk edge.
- q values are defined only after settling.
REQ-012 No enable, load or direction input exists; the counter decrements on every rising clk edge while reset is high.
REQ-013 Falling edges of clk SHALL NOT change q.
REQ-014 The implementation SHALL contain no clocked logic other than the T flip-flop chain.
- No synchronous re-timing of q.
- No combinational decode on q.

Reset
REQ-015 While reset is low, q SHALL be 0 immediately (asynchronously) and SHALL hold 0 regardless of clk activity.
REQ-016 Reset asserted mid-count SHALL clear all stages at once, without waiting for a clk edge.
- The clear SHALL NOT produce spurious ripple toggles in higher stages.
- Stages cleared from 1 to 0 produce falling edges only, so no stage is triggered.
REQ-017 After reset is released (high), the first rising clk edge SHALL produce q = all ones.
- Counting then continues downward.
REQ-018 If reset releases coincident with a rising clk edge, that edge MAY be ignored.
- Counting SHALL start correctly by the following edge.

Verification
REQ-019 Power-up reset.
- Stimulus: reset=0 for 10 ns with clk period 10 ns.
- Response: q=0000 throughout, and no change on clk edges.
REQ-020 Basic count.
- Stimulus: release reset, apply 5 rising edges.
- Response: q settles to 1111, 1110, 1101, 1100, 1011 in order.
REQ-021 Full cycle and wrap.
- Stimulus: from reset, apply 16 rising edges.
- Response: q returns to 0000 after the 16th edge.
- Response: q reads 1111 after the 17th edge.
REQ-022 Mid-count asynchronous reset.
- Stimulus: count to 1010, then drive reset=0 between clk edges.
- Response: q=0000 immediately, with no glitch to any other nonzero value.
- Response: after release, the next edge gives 1111.
REQ-023 Reset held with clock running.
- Stimulus: reset=0 for 10 clk cycles.
- Response: q stays 0000.
REQ-024 Long run of 20 clk cycles from reset.
- Stimulus: release reset, run 20 clk cycles.
- Response: after each edge plus settling, q equals (0 - n) mod 16, checked against a reference model.
